// File: rtl/ram_bist_ctrl_if.sv
// RAM control/data bus between the BIST controller (master) and the
// synchronous single-port RAM (slave).
interface ram_bist_ctrl_if #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 8
);
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          ram_cs;
  logic          ram_wr;
  logic          ram_rd;

  modport master (
    output ram_addr, ram_wdata, ram_cs, ram_wr, ram_rd,
    input  ram_rdata
  );

  modport slave (
    input  ram_addr, ram_wdata, ram_cs, ram_wr, ram_rd,
    output ram_rdata
  );
endinterface

// File: rtl/ram_bist_ctrl.sv
// RAM BIST controller: writes k*STEP to every address, reads all words back,
// and reports pass/fail, a saturating error count and the first failing address.
module ram_bist_ctrl #(
  parameter int unsigned AW   = 10,
  parameter int unsigned DW   = 8,
  parameter int unsigned STEP = 2,
  parameter int unsigned CW   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CW-1:0]       err_count,
  output logic [AW-1:0]       fail_addr,
  ram_bist_ctrl_if.master     ram
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   k_q, k_d;
  logic [CW-1:0]   err_q, err_d;
  logic [AW-1:0]   fail_q, fail_d;
  logic            pass_q, pass_d;
  logic            cmp_vld_q, cmp_vld_d;
  logic [DW-1:0]   cmp_exp_q, cmp_exp_d;
  logic [AW-1:0]   cmp_addr_q, cmp_addr_d;
  logic [AW+DW-1:0] pat;
  logic            mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      err_q      <= '0;
      fail_q     <= '0;
      pass_q     <= 1'b0;
      cmp_vld_q  <= 1'b0;
      cmp_exp_q  <= '0;
      cmp_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      err_q      <= err_d;
      fail_q     <= fail_d;
      pass_q     <= pass_d;
      cmp_vld_q  <= cmp_vld_d;
      cmp_exp_q  <= cmp_exp_d;
      cmp_addr_q <= cmp_addr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    err_d         = err_q;
    fail_d        = fail_q;
    pass_d        = pass_q;
    cmp_vld_d     = 1'b0;
    cmp_exp_d     = cmp_exp_q;
    cmp_addr_d    = cmp_addr_q;
    busy          = 1'b0;
    done          = 1'b0;
    ram.ram_addr  = '0;
    ram.ram_wdata = '0;
    ram.ram_cs    = 1'b0;
    ram.ram_wr    = 1'b0;
    ram.ram_rd    = 1'b0;
    pat           = (AW+DW)'(k_q) * (AW+DW)'(STEP);

    // Compare of the read issued last cycle; err_q==0 marks "no mismatch yet"
    // because the counter saturates and never wraps back to zero.
    mismatch = cmp_vld_q && (ram.ram_rdata != cmp_exp_q);
    if (mismatch) begin
      if (err_q != '1) err_d = err_q + 1'b1;
      if (err_q == '0) fail_d = cmp_addr_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WRITE;
          k_d     = '0;
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
        end
      end
      S_WRITE: begin
        busy          = 1'b1;
        ram.ram_cs    = 1'b1;
        ram.ram_wr    = 1'b1;
        ram.ram_addr  = k_q;
        ram.ram_wdata = pat[DW-1:0];
        k_d           = k_q + 1'b1;
        if (k_q == '1) state_d = S_READ;
        if (abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end
      end
      S_READ: begin
        busy         = 1'b1;
        ram.ram_cs   = 1'b1;
        ram.ram_rd   = 1'b1;
        ram.ram_addr = k_q;
        cmp_vld_d    = 1'b1;
        cmp_exp_d    = pat[DW-1:0];
        cmp_addr_d   = k_q;
        k_d          = k_q + 1'b1;
        if (k_q == '1) state_d = S_DRAIN;
        if (abort) begin
          state_d   = S_IDLE;
          cmp_vld_d = 1'b0;
          pass_d    = 1'b0;
        end
      end
      S_DRAIN: begin
        busy    = 1'b1;
        state_d = S_DONE;
        pass_d  = (err_d == '0);
        if (abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_addr = fail_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: small (AW=4, STEP=2) instance with fault-injecting
// RAM model and scoreboard, plus a large (AW=8, STEP=3) instance.
module tb_ram_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- small instance ----------------
  logic        start4 = 1'b0, abort4 = 1'b0;
  logic        busy4, done4, pass4;
  logic [15:0] err4;
  logic [3:0]  fail4;
  ram_bist_ctrl_if #(.AW(4), .DW(8)) bus4();

  ram_bist_ctrl #(.AW(4), .DW(8), .STEP(2), .CW(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
    .busy(busy4), .done(done4), .pass(pass4),
    .err_count(err4), .fail_addr(fail4), .ram(bus4)
  );

  logic [7:0] mem4 [16];
  logic       fault4 [16];
  always @(posedge clk) begin
    if (bus4.ram_cs && bus4.ram_wr) mem4[bus4.ram_addr] <= bus4.ram_wdata;
    if (bus4.ram_cs && bus4.ram_rd)
      bus4.ram_rdata <= mem4[bus4.ram_addr] | {7'b0, fault4[bus4.ram_addr]};
  end

  typedef struct {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;
    int         cyc;
  } txn_t;
  txn_t sbq[$];

  int e0_4 = 0, done_cnt4 = 0, done_cyc4 = 0;
  logic        snap_pass4, snap_busy4;
  logic [15:0] snap_err4;
  logic [3:0]  snap_fail4;

  // Scoreboard side: every RAM access is popped and compared against the queue.
  always @(negedge clk) begin
    int n;
    txn_t e;
    n = edge_cnt - e0_4 + 1;
    if (rst_n) begin
      if (bus4.ram_cs) begin
        checks++;
        if (bus4.ram_wr && bus4.ram_rd) begin
          errors++;
          $display("FAIL wr_rd_excl: wr=%0b rd=%0b required not both 1", bus4.ram_wr, bus4.ram_rd);
        end
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: access wr=%0b addr=%0d cycle=%0d with empty queue",
                   bus4.ram_wr, bus4.ram_addr, n);
        end else begin
          e = sbq.pop_front();
          if (bus4.ram_wr !== e.wr || bus4.ram_addr !== e.addr || n != e.cyc ||
              (e.wr && bus4.ram_wdata !== e.data)) begin
            errors++;
            $display("FAIL sb_access: got wr=%0b addr=%0d data=%0d cyc=%0d required wr=%0b addr=%0d data=%0d cyc=%0d",
                     bus4.ram_wr, bus4.ram_addr, bus4.ram_wdata, n, e.wr, e.addr, e.data, e.cyc);
          end
        end
      end
      if (done4) begin
        done_cnt4++;
        done_cyc4  = n;
        snap_pass4 = pass4;
        snap_busy4 = busy4;
        snap_err4  = err4;
        snap_fail4 = fail4;
      end
    end
  end

  // ---------------- large instance ----------------
  logic        start8 = 1'b0;
  logic        busy8, done8, pass8;
  logic [15:0] err8;
  logic [7:0]  fail8;
  ram_bist_ctrl_if #(.AW(8), .DW(8)) bus8();

  ram_bist_ctrl #(.AW(8), .DW(8), .STEP(3), .CW(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .abort(1'b0),
    .busy(busy8), .done(done8), .pass(pass8),
    .err_count(err8), .fail_addr(fail8), .ram(bus8)
  );

  logic [7:0] mem8 [256];
  always @(posedge clk) begin
    if (bus8.ram_cs && bus8.ram_wr) mem8[bus8.ram_addr] <= bus8.ram_wdata;
    if (bus8.ram_cs && bus8.ram_rd) bus8.ram_rdata <= mem8[bus8.ram_addr];
  end

  int e0_8 = 0, done_cnt8 = 0, done_cyc8 = 0, wr100_cnt = 0;
  logic [7:0] wd100 = '0;
  logic       snap_pass8 = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus8.ram_cs && bus8.ram_wr && bus8.ram_addr == 8'd100) begin
        wd100 = bus8.ram_wdata;
        wr100_cnt++;
      end
      if (done8) begin
        done_cnt8++;
        done_cyc8  = edge_cnt - e0_8 + 1;
        snap_pass8 = pass8;
      end
    end
  end

  // ---------------- stimulus helpers (no checks) ----------------
  task automatic kick4();
    txn_t t;
    @(posedge clk); #1;
    start4 = 1'b1;
    for (int unsigned k = 0; k < 16; k++) begin
      t.wr = 1'b1; t.addr = 4'(k); t.data = 8'(k * 2); t.cyc = int'(k) + 1;
      sbq.push_back(t);
    end
    for (int unsigned k = 0; k < 16; k++) begin
      t.wr = 1'b0; t.addr = 4'(k); t.data = '0; t.cyc = 17 + int'(k);
      sbq.push_back(t);
    end
    @(posedge clk); #1;
    e0_4 = edge_cnt;
    start4 = 1'b0;
    done_cnt4 = 0;
  endtask

  task automatic wait_done4(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done_cnt4 != 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run4(input logic exp_pass, input logic [15:0] exp_err,
                      input logic [3:0] exp_fail, input string tag);
    bit ok;
    kick4();
    wait_done4(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: no done within budget, required done", tag);
    end
    checks++;
    if (done_cnt4 != 1 || done_cyc4 != 34) begin
      errors++;
      $display("FAIL %s_done: count=%0d cycle=%0d required count=1 cycle=34", tag, done_cnt4, done_cyc4);
    end
    checks++;
    if (snap_pass4 !== exp_pass || snap_err4 !== exp_err || snap_fail4 !== exp_fail || snap_busy4 !== 1'b0) begin
      errors++;
      $display("FAIL %s_result: pass=%0b err=%0d fail=%0d busy=%0b required pass=%0b err=%0d fail=%0d busy=0",
               tag, snap_pass4, snap_err4, snap_fail4, snap_busy4, exp_pass, exp_err, exp_fail);
    end
    checks++;
    if (pass4 !== exp_pass || sbq.size() != 0) begin
      errors++;
      $display("FAIL %s_hold: pass=%0b queue=%0d required pass=%0b queue=0", tag, pass4, sbq.size(), exp_pass);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    checks++;
    if ({busy4, done4, pass4, err4, fail4, bus4.ram_addr, bus4.ram_wdata,
         bus4.ram_cs, bus4.ram_wr, bus4.ram_rd} !== '0) begin
      errors++;
      $display("FAIL reset4: busy=%0b done=%0b pass=%0b err=%0d fail=%0d cs=%0b required all 0",
               busy4, done4, pass4, err4, fail4, bus4.ram_cs);
    end
    checks++;
    if ({busy8, done8, pass8, err8, fail8, bus8.ram_cs, bus8.ram_wr, bus8.ram_rd} !== '0) begin
      errors++;
      $display("FAIL reset8: busy=%0b done=%0b pass=%0b cs=%0b required all 0", busy8, done8, pass8, bus8.ram_cs);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_pass();
    run4(1'b1, 16'd0, 4'd0, "pass");
  endtask

  task automatic test_single_fault();
    fault4[5] = 1'b1;
    run4(1'b0, 16'd1, 4'd5, "fault5");
    fault4[5] = 1'b0;
  endtask

  task automatic test_two_faults();
    fault4[3] = 1'b1;
    fault4[9] = 1'b1;
    run4(1'b0, 16'd2, 4'd3, "fault3_9");
    fault4[3] = 1'b0;
    fault4[9] = 1'b0;
    run4(1'b1, 16'd0, 4'd0, "rerun");
  endtask

  task automatic test_abort();
    bit seen;
    kick4();
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus4.ram_rd && bus4.ram_addr == 4'd7) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL abort_reach: read of addr 7 not observed, required observed");
    end
    abort4 = 1'b1;
    @(posedge clk); #1;
    abort4 = 1'b0;
    sbq.delete();
    checks++;
    if (busy4 !== 1'b0 || bus4.ram_cs !== 1'b0 || pass4 !== 1'b0) begin
      errors++;
      $display("FAIL abort_drop: busy=%0b cs=%0b pass=%0b required 0 0 0", busy4, bus4.ram_cs, pass4);
    end
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (done_cnt4 != 0 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL abort_nodone: done_count=%0d busy=%0b required 0 0", done_cnt4, busy4);
    end
    run4(1'b1, 16'd0, 4'd0, "after_abort");
  endtask

  task automatic test_async_reset();
    kick4();
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy4, done4, pass4, err4, fail4, bus4.ram_addr, bus4.ram_wdata,
         bus4.ram_cs, bus4.ram_wr, bus4.ram_rd} !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%0b cs=%0b wr=%0b addr=%0d wdata=%0d required all 0",
               busy4, bus4.ram_cs, bus4.ram_wr, bus4.ram_addr, bus4.ram_wdata);
    end
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run4(1'b1, 16'd0, 4'd0, "after_reset");
  endtask

  task automatic test_back_to_back();
    bit ok;
    @(posedge clk); #1;
    start8 = 1'b1;
    @(posedge clk); #1;
    e0_8 = edge_cnt;
    start8 = 1'b0;
    done_cnt8 = 0;
    wr100_cnt = 0;
    repeat (50) @(posedge clk);
    #1;
    start8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(posedge clk); #1;
      if (done_cnt8 != 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (!ok || done_cnt8 != 1 || done_cyc8 != 514) begin
      errors++;
      $display("FAIL restart_done: seen=%0b count=%0d cycle=%0d required 1 1 514", ok, done_cnt8, done_cyc8);
    end
    checks++;
    if (wd100 !== 8'd44 || wr100_cnt != 1) begin
      errors++;
      $display("FAIL restart_pattern: addr100 data=%0d writes=%0d required data=44 writes=1", wd100, wr100_cnt);
    end
    checks++;
    if (snap_pass8 !== 1'b1 || err8 !== 16'd0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL restart_result: pass=%0b err=%0d busy=%0b required 1 0 0", snap_pass8, err8, busy8);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) fault4[i] = 1'b0;
    test_reset();
    test_pass();
    test_single_fault();
    test_two_faults();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
Upstream stage for the synchronous single-port RAM (10-bit addr, 8-bit data, active-high cs/wr/rd, 1-cycle registered read). On start, it writes a deterministic pattern to every address, reads every address back, and compares each word with the expected value. It reports pass/fail, a saturating error count and the first failing address. It owns the RAM control pins exclusively while busy.

Parameters:
AW, 10, RAM address width; DEPTH = 2**AW words
DW, 8, RAM data width
STEP, 2, pattern multiplier; expected word at address k = (k*STEP) mod 2**DW
CW, 16, err_count width

Ports:
clk  in  1  rising-edge clock, shared with RAM
rst_n  in  1  asynchronous active-low reset
start  in  1  begin test; sampled only in IDLE
abort  in  1  cancel test; sampled in any busy state
busy  out  1  high from first RAM access through last compare
done  out  1  one-cycle pulse at normal completion
pass  out  1  1 = last completed test had zero errors; held until next start
err_count  out  CW  mismatch count, saturating at all-ones
fail_addr  out  AW  address of first mismatch; valid when pass=0 after done
ram_addr  out  AW  RAM address
ram_wdata  out  DW  RAM write data
ram_rdata  in  DW  RAM read data, valid the cycle after a read is issued
ram_cs  out  1  RAM chip select
ram_wr  out  1  RAM write enable
ram_rd  out  1  RAM read enable

Behaviour:
- Reset (async, immediate, no clock needed): state IDLE. All outputs 0: busy, done, pass, err_count, fail_addr, ram_addr, ram_wdata, ram_cs, ram_wr, ram_rd.
- States: IDLE -> WRITE -> READ -> DRAIN -> DONE -> IDLE.
- IDLE: ram_cs/wr/rd = 0.
  - start=1 at edge E0 clears err_count, fail_addr and pass, sets k=0, and enters WRITE.
  - busy rises in the cycle after E0.
- WRITE: DEPTH cycles. Each cycle drives ram_cs=1, ram_wr=1, ram_rd=0, ram_addr=k, ram_wdata=(k*STEP)[DW-1:0], then k++. After k=DEPTH-1, go to READ with k=0 (no idle cycle between phases).
- READ: DEPTH cycles. Each cycle drives ram_cs=1, ram_rd=1, ram_wr=0, ram_addr=k, then k++.
  - Expected value and address are pipelined one stage.
  - ram_rdata is compared in the following cycle.
- DRAIN: 1 cycle with ram_cs/rd/wr = 0; completes the last compare (address DEPTH-1).
- DONE: done=1 for one cycle, busy=0, pass=(err_count==0). Next state IDLE.
- Timing: write cycles are 1..DEPTH after E0, reads DEPTH+1..2*DEPTH, drain 2*DEPTH+1, done pulse 2*DEPTH+2.
- Compare rule:
  - Mismatch increments err_count, saturating at 2**CW-1.
  - fail_addr latches on the first mismatch only; later mismatches do not update it.
- Invariants: ram_wr and ram_rd are never both 1. ram_cs=0 whenever the block is not in WRITE or READ.
- Pattern arithmetic: k*STEP is computed with at least AW+DW bits, then truncated to DW. Address counter k wraps cleanly at DEPTH; it never overruns.
- start while busy: ignored, with no restart and no extra done.
- abort=1 in WRITE/READ/DRAIN:
  - Next state IDLE; RAM controls drop at that edge.
  - busy=0, no done pulse, pass=0. err_count and fail_addr keep their partial values.
  - abort and start together in IDLE: start wins (abort is ignored in IDLE).
- Reset mid-operation: async clear to reset values; the RAM contents are left as-is.

Test Plan:
1. AW=4, STEP=2, fault-free 1-cycle-latency RAM model; reset then pulse start -> writes 0,2,...,30 to addr 0..15; reads in cycles 17..32; done pulses in cycle 34 only; pass=1, err_count=0, wr&rd never both 1.
2. Same setup, RAM bit0 stuck-at-1 at addr 5 -> err_count=1, fail_addr=5, pass=0 at done.
3. Faults at addr 3 and 9 -> err_count=2, fail_addr=3; then a fault-free rerun -> pass=1, err_count=0, fail_addr=0.
4. abort during READ while ram_addr=7 -> next cycle busy=0, ram_cs=0, no done; the following start completes normally.
5. rst_n low mid-WRITE between clock edges -> all outputs 0 immediately; after release, start runs a full passing test.
6. AW=8, STEP=3, start re-pulsed while busy -> addr 100 written with 44 (300 mod 256); exactly one done pulse, in cycle 514.
